// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle between the PS master and the PL register front end.
interface axi_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_slave_fe.sv
// AXI4-Lite responder front end: turns each AXI transaction into one internal
// we/re strobe, with region rejection, strobe checking and a per-access timeout.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order), readies high for uncaptured channels
// W_EXEC | we held until wdone or timeout
// W_RESP | bvalid held until bready
// R_IDLE | arready high
// R_EXEC | re held until rdone or timeout
// R_RESP | rvalid held until rready
module axi_lite_slave_fe #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   axi_lite_if.slave         s_axi,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   input  logic              wdone,
   output logic              re,
   output logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rdone
);
   localparam int             STRB_W   = DATA_W / 8;
   localparam int             CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic           TO_EN    = (TIMEOUT > 0);
   localparam logic [1:0]     RESP_OKAY   = 2'b00;
   localparam logic [1:0]     RESP_SLVERR = 2'b10;
   localparam logic [1:0]     RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_t;

   w_state_t          w_state, w_state_d;
   r_state_t          r_state, r_state_d;
   logic              alive;
   logic              aw_cap, aw_cap_d, w_cap, w_cap_d;
   logic [ADDR_W-1:0] waddr_d, raddr_d;
   logic [DATA_W-1:0] wdata_d, rdata_q, rdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [CNT_W-1:0]  wcnt, wcnt_d, rcnt, rcnt_d;

   // Readies stay low during reset and come up one cycle after release.
   assign s_axi.awready = alive && (w_state == W_IDLE) && !aw_cap;
   assign s_axi.wready  = alive && (w_state == W_IDLE) && !w_cap;
   assign s_axi.arready = alive && (r_state == R_IDLE);
   assign s_axi.bvalid  = (w_state == W_RESP);
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = (r_state == R_RESP);
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;
   assign we            = (w_state == W_EXEC);
   assign re            = (r_state == R_EXEC);

   always_comb begin
      w_state_d = w_state;
      aw_cap_d  = aw_cap;
      w_cap_d   = w_cap;
      waddr_d   = waddr;
      wdata_d   = wdata;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      wcnt_d    = wcnt;
      case (w_state)
         W_IDLE: begin
            if (s_axi.awvalid && s_axi.awready) begin
               aw_cap_d = 1'b1;
               waddr_d  = s_axi.awaddr;
            end
            if (s_axi.wvalid && s_axi.wready) begin
               w_cap_d = 1'b1;
               wdata_d = s_axi.wdata;
               wstrb_d = s_axi.wstrb;
            end
            // Decide in the completing handshake cycle so we rises next cycle.
            if (aw_cap_d && w_cap_d) begin
               if (waddr_d[ADDR_W-1 -: 2] == 2'b11) begin
                  bresp_d   = RESP_DECERR;
                  w_state_d = W_RESP;
               end else if (wstrb_d != '1) begin
                  bresp_d   = RESP_SLVERR;
                  w_state_d = W_RESP;
               end else begin
                  wcnt_d    = '0;
                  w_state_d = W_EXEC;
               end
            end
         end
         W_EXEC: begin
            if (wdone) begin
               bresp_d   = RESP_OKAY;
               w_state_d = W_RESP;
            end else if (TO_EN && (wcnt == CNT_LAST)) begin
               bresp_d   = RESP_SLVERR;
               w_state_d = W_RESP;
            end else begin
               wcnt_d = wcnt + CNT_W'(1);
            end
         end
         W_RESP: begin
            if (s_axi.bready) begin
               aw_cap_d  = 1'b0;
               w_cap_d   = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state;
      raddr_d   = raddr;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rcnt_d    = rcnt;
      case (r_state)
         R_IDLE: begin
            if (s_axi.arvalid && s_axi.arready) begin
               raddr_d   = s_axi.araddr;
               rcnt_d    = '0;
               r_state_d = R_EXEC;
            end
         end
         R_EXEC: begin
            if (rdone) begin
               rdata_d   = rdata;
               rresp_d   = RESP_OKAY;
               r_state_d = R_RESP;
            end else if (TO_EN && (rcnt == CNT_LAST)) begin
               rdata_d   = '0;
               rresp_d   = RESP_SLVERR;
               r_state_d = R_RESP;
            end else begin
               rcnt_d = rcnt + CNT_W'(1);
            end
         end
         R_RESP: begin
            if (s_axi.rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alive   <= 1'b0;
         w_state <= W_IDLE;
         aw_cap  <= 1'b0;
         w_cap   <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
         wstrb_q <= '0;
         bresp_q <= RESP_OKAY;
         wcnt    <= '0;
      end else begin
         alive   <= 1'b1;
         w_state <= w_state_d;
         aw_cap  <= aw_cap_d;
         w_cap   <= w_cap_d;
         waddr   <= waddr_d;
         wdata   <= wdata_d;
         wstrb_q <= wstrb_d;
         bresp_q <= bresp_d;
         wcnt    <= wcnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= R_IDLE;
         raddr   <= '0;
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
         rcnt    <= '0;
      end else begin
         r_state <= r_state_d;
         raddr   <= raddr_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         rcnt    <= rcnt_d;
      end
   end
endmodule

// File: tb/tb_axi_lite_slave_fe.sv
// Self-checking bench for axi_lite_slave_fe: directed scenarios plus randomized
// write/read traffic against a register-map reference model.
module tb_axi_lite_slave_fe;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) s_axi ();
   axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) t_axi ();

   logic          we, re, wdone, rdone;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata, rdata;
   logic          t_we, t_re;
   logic [AW-1:0] t_waddr, t_raddr;
   logic [DW-1:0] t_wdata;

   axi_lite_slave_fe #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .s_axi(s_axi),
      .we(we), .waddr(waddr), .wdata(wdata), .wdone(wdone),
      .re(re), .raddr(raddr), .rdata(rdata), .rdone(rdone));

   axi_lite_slave_fe #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut_to (
      .clk(clk), .rst(rst), .s_axi(t_axi),
      .we(t_we), .waddr(t_waddr), .wdata(t_wdata), .wdone(1'b0),
      .re(t_re), .raddr(t_raddr), .rdata(32'hFFFF_FFFF), .rdone(1'b0));

   // Decoder stand-in: either auto-acknowledges from a small register array or
   // follows manual done/data drives.
   logic          auto_wdone, auto_rdone, wdone_drv, rdone_drv;
   logic [DW-1:0] rdata_drv;
   logic [DW-1:0] dmem [16];
   assign wdone = auto_wdone ? we : wdone_drv;
   assign rdone = auto_rdone ? re : rdone_drv;
   assign rdata = auto_rdone ? dmem[raddr[5:2]] : rdata_drv;

   int            cyc = 0;
   int            we_cycles = 0;
   logic [AW-1:0] log_addr [$];
   logic [DW-1:0] log_data [$];
   int            log_cyc [$];

   always @(posedge clk) begin
      cyc++;
      if (we) we_cycles++;
      if (rst) begin
         for (int i = 0; i < 16; i++) dmem[i] <= '0;
      end else if (we && wdone) begin
         log_addr.push_back(waddr);
         log_data.push_back(wdata);
         log_cyc.push_back(cyc);
         dmem[waddr[5:2]] <= wdata;
      end
   end

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] ref_mem [16];

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic bound_fail(input string what);
      checks++;
      failures++;
      $display("FAIL %s handshake bound expired got=timeout exp=handshake", what);
   endtask

   task automatic send_aw(input logic [AW-1:0] a, input int dly);
      repeat (dly) @(negedge clk);
      s_axi.awaddr = a; s_axi.awvalid = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (s_axi.awready) begin @(negedge clk); s_axi.awvalid = 1'b0; return; end
         @(negedge clk);
      end
      s_axi.awvalid = 1'b0;
      bound_fail("aw");
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s, input int dly);
      repeat (dly) @(negedge clk);
      s_axi.wdata = d; s_axi.wstrb = s; s_axi.wvalid = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (s_axi.wready) begin @(negedge clk); s_axi.wvalid = 1'b0; return; end
         @(negedge clk);
      end
      s_axi.wvalid = 1'b0;
      bound_fail("w");
   endtask

   task automatic send_ar(input logic [AW-1:0] a, input int dly);
      repeat (dly) @(negedge clk);
      s_axi.araddr = a; s_axi.arvalid = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (s_axi.arready) begin @(negedge clk); s_axi.arvalid = 1'b0; return; end
         @(negedge clk);
      end
      s_axi.arvalid = 1'b0;
      bound_fail("ar");
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int da, input int dw);
      fork
         send_aw(a, da);
         send_w(d, s, dw);
      join
   endtask

   task automatic wait_b(output logic [1:0] resp, input int dly);
      resp = 2'bxx;
      for (int k = 0; k < 600 && !s_axi.bvalid; k++) @(negedge clk);
      if (!s_axi.bvalid) begin bound_fail("b"); return; end
      resp = s_axi.bresp;
      repeat (dly) @(negedge clk);
      s_axi.bready = 1'b1; @(negedge clk); s_axi.bready = 1'b0;
   endtask

   task automatic wait_r(output logic [1:0] resp, output logic [DW-1:0] d, input int dly);
      resp = 2'bxx; d = 'x;
      for (int k = 0; k < 600 && !s_axi.rvalid; k++) @(negedge clk);
      if (!s_axi.rvalid) begin bound_fail("r"); return; end
      resp = s_axi.rresp; d = s_axi.rdata;
      repeat (dly) @(negedge clk);
      s_axi.rready = 1'b1; @(negedge clk); s_axi.rready = 1'b0;
   endtask

   function automatic logic [1:0] model_bresp(input logic [AW-1:0] a, input logic [3:0] s);
      if (a[31:30] == 2'b11) return 2'b11;
      if (s != 4'hF) return 2'b10;
      return 2'b00;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({we, re, s_axi.bvalid, s_axi.rvalid} !== 4'b0) begin
         failures++; $display("FAIL reset_strobes got=%b exp=0000", {we, re, s_axi.bvalid, s_axi.rvalid});
      end
      checks++;
      if ({waddr, wdata, raddr, s_axi.rdata, s_axi.bresp, s_axi.rresp} !== '0) begin
         failures++; $display("FAIL reset_payload got=%h/%h/%h/%h exp=0", waddr, wdata, raddr, s_axi.rdata);
      end
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b000) begin
         failures++; $display("FAIL reset_readies got=%b exp=000", {s_axi.awready, s_axi.wready, s_axi.arready});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
         failures++; $display("FAIL release_readies got=%b exp=111", {s_axi.awready, s_axi.wready, s_axi.arready});
      end
      @(negedge clk);
   endtask

   task automatic test_write_same_cycle();
      int base_we = we_cycles;
      auto_wdone = 1'b1;
      axi_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 32'h10, 32'hDEAD_BEEF}) begin
         failures++; $display("FAIL same_cycle_we got=%b %h %h exp=1 00000010 deadbeef", we, waddr, wdata);
      end
      @(negedge clk);
      checks++;
      if ({we, s_axi.bvalid, s_axi.bresp} !== 4'b0100) begin
         failures++; $display("FAIL same_cycle_b got=we%b bv%b br%b exp=we0 bv1 br00", we, s_axi.bvalid, s_axi.bresp);
      end
      s_axi.bready = 1'b1; @(negedge clk); s_axi.bready = 1'b0;
      checks++;
      if (we_cycles - base_we !== 1) begin
         failures++; $display("FAIL same_cycle_we_len got=%0d exp=1", we_cycles - base_we);
      end
   endtask

   task automatic test_write_w_first();
      int base_we = we_cycles;
      logic [DW-1:0] wd = $urandom;
      logic ok = 1'b1;
      auto_wdone = 1'b0; wdone_drv = 1'b0;
      fork
         begin
            send_w(wd, 4'hF, 0);
            checks++;
            if (s_axi.wready !== 1'b0) begin
               failures++; $display("FAIL w_first_wready got=%b exp=0", s_axi.wready);
            end
         end
         send_aw(32'h8000_0004, 3);
      join
      checks++;
      if ({we, waddr, wdata} !== {1'b1, 32'h8000_0004, wd}) begin
         failures++; $display("FAIL w_first_we got=%b %h %h exp=1 80000004 %h", we, waddr, wdata, wd);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (we !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL w_first_we_hold got=dropped exp=held"); end
      wdone_drv = 1'b1; @(negedge clk); wdone_drv = 1'b0;
      checks++;
      if ({we, s_axi.bvalid, s_axi.bresp} !== 4'b0100) begin
         failures++; $display("FAIL w_first_b got=we%b bv%b br%b exp=we0 bv1 br00", we, s_axi.bvalid, s_axi.bresp);
      end
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if ({s_axi.bvalid, s_axi.bresp} !== 3'b100) ok = 1'b0;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL w_first_b_stable got=changed exp=stable"); end
      s_axi.bready = 1'b1; @(negedge clk); s_axi.bready = 1'b0;
      checks++;
      if (s_axi.bvalid !== 1'b0 || we_cycles - base_we !== 6) begin
         failures++; $display("FAIL w_first_done got=bv%b len%0d exp=bv0 len6", s_axi.bvalid, we_cycles - base_we);
      end
      checks++;
      if (log_addr.size() == 0 || log_addr[$] !== 32'h8000_0004 || log_data[$] !== wd) begin
         failures++; $display("FAIL w_first_strobe got=missing_or_wrong exp=80000004/%h", wd);
      end
   endtask

   task automatic test_errors();
      logic [1:0] resp;
      int base_we = we_cycles;
      auto_wdone = 1'b1;
      axi_write(32'hC000_0000, $urandom, 4'hF, 0, 1);
      wait_b(resp, 0);
      checks++;
      if (resp !== model_bresp(32'hC000_0000, 4'hF)) begin
         failures++; $display("FAIL decerr_resp got=%b exp=11", resp);
      end
      axi_write(32'h0000_0000, $urandom, 4'h3, 1, 0);
      wait_b(resp, 2);
      checks++;
      if (resp !== model_bresp(32'h0, 4'h3)) begin
         failures++; $display("FAIL slverr_resp got=%b exp=10", resp);
      end
      checks++;
      if (we_cycles !== base_we) begin
         failures++; $display("FAIL err_no_we got=%0d exp=0", we_cycles - base_we);
      end
   endtask

   task automatic test_read_concurrent();
      logic [1:0] resp;
      logic [DW-1:0] wd = $urandom;
      auto_wdone = 1'b1; auto_rdone = 1'b0; rdone_drv = 1'b0;
      fork
         begin
            send_ar(32'h0000_0008, 0);
            checks++;
            if ({re, raddr} !== {1'b1, 32'h8}) begin
               failures++; $display("FAIL read_re got=%b %h exp=1 00000008", re, raddr);
            end
            @(negedge clk);
            rdone_drv = 1'b1; rdata_drv = 32'h1234_5678;
            @(negedge clk);
            rdone_drv = 1'b0; rdata_drv = $urandom;
            checks++;
            if ({re, s_axi.rvalid, s_axi.rresp, s_axi.rdata} !== {1'b0, 1'b1, 2'b00, 32'h1234_5678}) begin
               failures++; $display("FAIL read_resp got=re%b rv%b rr%b %h exp=re0 rv1 rr00 12345678",
                                    re, s_axi.rvalid, s_axi.rresp, s_axi.rdata);
            end
            s_axi.rready = 1'b1; @(negedge clk); s_axi.rready = 1'b0;
         end
         begin
            axi_write(32'h0000_0014, wd, 4'hF, 0, 0);
            wait_b(resp, 1);
         end
      join
      checks++;
      if (resp !== 2'b00 || log_addr[$] !== 32'h14 || log_data[$] !== wd) begin
         failures++; $display("FAIL concurrent_write got=%b %h %h exp=00 00000014 %h", resp, log_addr[$], log_data[$], wd);
      end
   endtask

   task automatic test_back_to_back();
      int base = log_addr.size();
      logic [DW-1:0] d [4];
      logic ok = 1'b1;
      auto_wdone = 1'b1; s_axi.bready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         axi_write(AW'(32'h40 + 4 * i), d[i], 4'hF, 0, 0);
      end
      repeat (3) @(negedge clk);
      s_axi.bready = 1'b0;
      checks++;
      if (log_addr.size() - base !== 4) begin
         failures++; $display("FAIL b2b_count got=%0d exp=4", log_addr.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (log_data[base + i] !== d[i] || log_addr[base + i] !== AW'(32'h40 + 4 * i)) ok = 1'b0;
            if (i > 0 && log_cyc[base + i] - log_cyc[base + i - 1] != 3) ok = 1'b0;
         end
         if (!ok) begin failures++; $display("FAIL b2b_spacing got=irregular exp=3cycles_in_order"); end
      end
   endtask

   task automatic test_timeout_boundary();
      logic [1:0] resp;
      int base_we = we_cycles;
      auto_wdone = 1'b0; wdone_drv = 1'b0;
      axi_write(32'h0000_0018, $urandom, 4'hF, 0, 0);
      for (int k = 1; k < 255; k++) @(negedge clk);
      wdone_drv = 1'b1; @(negedge clk); wdone_drv = 1'b0;
      checks++;
      if ({s_axi.bvalid, s_axi.bresp} !== 3'b100 || we_cycles - base_we !== 255) begin
         failures++; $display("FAIL done_at_limit got=bv%b br%b len%0d exp=bv1 br00 len255",
                              s_axi.bvalid, s_axi.bresp, we_cycles - base_we);
      end
      s_axi.bready = 1'b1; @(negedge clk); s_axi.bready = 1'b0;
      base_we = we_cycles;
      axi_write(32'h0000_001C, $urandom, 4'hF, 0, 0);
      wait_b(resp, 0);
      checks++;
      if (resp !== 2'b10 || we_cycles - base_we !== 255) begin
         failures++; $display("FAIL timeout_255 got=br%b len%0d exp=br10 len255", resp, we_cycles - base_we);
      end
   endtask

   task automatic test_timeout();
      int cnt_we = 0, cnt_re = 0;
      t_axi.awaddr = 32'h30; t_axi.awvalid = 1'b1;
      t_axi.wdata = $urandom; t_axi.wstrb = 4'hF; t_axi.wvalid = 1'b1;
      t_axi.araddr = 32'h34; t_axi.arvalid = 1'b1;
      @(negedge clk);
      t_axi.awvalid = 1'b0; t_axi.wvalid = 1'b0; t_axi.arvalid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (t_we) cnt_we++;
         if (t_re) cnt_re++;
         if (!t_we && !t_re) break;
         @(negedge clk);
      end
      checks++;
      if (cnt_we !== 4 || cnt_re !== 4) begin
         failures++; $display("FAIL timeout4_len got=we%0d re%0d exp=we4 re4", cnt_we, cnt_re);
      end
      checks++;
      if ({t_axi.bvalid, t_axi.bresp, t_axi.rvalid, t_axi.rresp, t_axi.rdata} !== {1'b1, 2'b10, 1'b1, 2'b10, 32'h0}) begin
         failures++; $display("FAIL timeout4_resp got=bv%b br%b rv%b rr%b %h exp=bv1 br10 rv1 rr10 0",
                              t_axi.bvalid, t_axi.bresp, t_axi.rvalid, t_axi.rresp, t_axi.rdata);
      end
      t_axi.bready = 1'b1; t_axi.rready = 1'b1; @(negedge clk);
      t_axi.bready = 1'b0; t_axi.rready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      auto_wdone = 1'b0; wdone_drv = 1'b0; auto_rdone = 1'b0; rdone_drv = 1'b0;
      fork
         axi_write(32'h0000_0020, 32'h0BAD_F00D, 4'hF, 0, 0);
         send_ar(32'h0000_0024, 0);
      join
      rdone_drv = 1'b1; rdata_drv = 32'hA5A5_5A5A;
      @(negedge clk);
      rdone_drv = 1'b0;
      checks++;
      if ({we, s_axi.rvalid} !== 2'b11) begin
         failures++; $display("FAIL mid_setup got=we%b rv%b exp=we1 rv1", we, s_axi.rvalid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({we, re, s_axi.bvalid, s_axi.rvalid, s_axi.awready, s_axi.wready, s_axi.arready} !== 7'b0) begin
         failures++; $display("FAIL mid_reset_ctrl got=%b exp=0000000",
                              {we, re, s_axi.bvalid, s_axi.rvalid, s_axi.awready, s_axi.wready, s_axi.arready});
      end
      checks++;
      if ({waddr, wdata, raddr, s_axi.rdata, s_axi.bresp, s_axi.rresp} !== '0) begin
         failures++; $display("FAIL mid_reset_payload got=%h/%h/%h/%h exp=0", waddr, wdata, raddr, s_axi.rdata);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
         failures++; $display("FAIL mid_release_readies got=%b exp=111", {s_axi.awready, s_axi.wready, s_axi.arready});
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (we || re || s_axi.bvalid || s_axi.rvalid) stale++;
      end
      checks++;
      if (stale !== 0) begin
         failures++; $display("FAIL mid_stale got=%0d exp=0", stale);
      end
   endtask

   task automatic test_random();
      logic [1:0]    resp, exp_resp;
      logic [AW-1:0] a, ra;
      logic [DW-1:0] d, rd;
      logic [3:0]    s;
      int            base_we, base_log;
      auto_wdone = 1'b1; auto_rdone = 1'b1;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      for (int it = 0; it < 40; it++) begin
         a = $urandom; a[1:0] = 2'b00;
         s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
         d = $urandom;
         base_we = we_cycles; base_log = log_addr.size();
         axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
         wait_b(resp, $urandom_range(0, 2));
         exp_resp = model_bresp(a, s);
         checks++;
         if (resp !== exp_resp) begin
            failures++; $display("FAIL rand_bresp it=%0d addr=%h strb=%h got=%b exp=%b", it, a, s, resp, exp_resp);
         end
         checks++;
         if (we_cycles - base_we !== ((exp_resp == 2'b00) ? 1 : 0) ||
             log_addr.size() - base_log !== ((exp_resp == 2'b00) ? 1 : 0)) begin
            failures++; $display("FAIL rand_we it=%0d got=%0d exp=%0d", it, we_cycles - base_we, (exp_resp == 2'b00) ? 1 : 0);
         end
         if (exp_resp == 2'b00) ref_mem[a[5:2]] = d;
         ra = $urandom; ra[1:0] = 2'b00;
         send_ar(ra, $urandom_range(0, 2));
         wait_r(resp, rd, $urandom_range(0, 2));
         checks++;
         if (resp !== 2'b00 || rd !== ref_mem[ra[5:2]]) begin
            failures++; $display("FAIL rand_read it=%0d addr=%h got=%b %h exp=00 %h", it, ra, resp, rd, ref_mem[ra[5:2]]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      auto_wdone = 1'b0; auto_rdone = 1'b0; wdone_drv = 1'b0; rdone_drv = 1'b0; rdata_drv = '0;
      s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
      s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
      t_axi.awaddr = '0; t_axi.awvalid = 1'b0; t_axi.wdata = '0; t_axi.wstrb = '0; t_axi.wvalid = 1'b0;
      t_axi.bready = 1'b0; t_axi.araddr = '0; t_axi.arvalid = 1'b0; t_axi.rready = 1'b0;
      @(negedge clk);
      test_reset();
      test_write_same_cycle();
      test_write_w_first();
      test_errors();
      test_read_concurrent();
      test_back_to_back();
      test_timeout_boundary();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axi_lite_slave_fe.md
# axi_lite_slave_fe

AXI4-Lite responder front end for the PL register space. It terminates the PS master's AXI4-Lite port and converts each transaction into one strobe on the simple internal bus: we/waddr/wdata/wdone for writes, re/raddr/rdata/rdone for reads. It sits directly upstream of axi_addr_decode. It owns handshaking, response codes, unmapped-region rejection and a per-access timeout.

## Interface
- ADDR_W, 32, AXI and internal address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- TIMEOUT, 255, max cycles to wait for wdone/rdone; 0 disables the timeout
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read data channel
- we, waddr, wdata  out  1/ADDR_W/DATA_W  internal write strobe, address and data
- wdone  in  1  write complete from the decoder (may be combinational from we)
- re, raddr  out  1/ADDR_W  internal read strobe and address
- rdata, rdone  in  DATA_W/1  read data and complete

## Operation
- The write FSM and read FSM are independent. A read and a write may be in flight together.
- Write FSM states:
  - W_IDLE: awready=!aw_captured and wready=!w_captured. AW and W are accepted in either order or in the same cycle. Each is latched on its handshake. Once both are held:
    - waddr[31:30]==2'b11: go to W_RESP with bresp=DECERR (2'b11). No we is issued.
    - wstrb != all-ones: go to W_RESP with bresp=SLVERR (2'b10). No we is issued.
    - Otherwise: go to W_EXEC.
  - W_EXEC: we=1 with waddr/wdata held stable. Leave W_EXEC on wdone=1 (bresp=OKAY) or on timeout (bresp=SLVERR). Move to W_RESP.
  - W_RESP: bvalid=1 with bresp stable. On bready go to W_IDLE and clear both capture flags.
- Read FSM states:
  - R_IDLE: arready=1. On handshake latch raddr and go to R_EXEC. Reads are not region-checked; all reads target CSR.
  - R_EXEC: re=1. On rdone, capture rdata into s_axi_rdata, set rresp=OKAY, go to R_RESP. On timeout, set s_axi_rdata=0 and rresp=SLVERR.
  - R_RESP: rvalid=1. On rready go to R_IDLE.
- Timeout counter: one per FSM, width clog2(TIMEOUT+1). It clears on entry to EXEC and increments each EXEC cycle without done. Timeout fires when count==TIMEOUT-1 and done is low, so the strobe is held at most TIMEOUT cycles. If done arrives in that same cycle, done wins.
- Only one outstanding transaction per direction. No ready is asserted on a channel while its FSM is outside IDLE.

## Timing
- Reset values:
  - we=0, re=0, bvalid=0, rvalid=0.
  - waddr, wdata, raddr, s_axi_rdata: all 0.
  - bresp=0, rresp=0.
  - awready=wready=arready=0 while rst is high. They become 1 the first cycle after release (IDLE).
- Write path:
  - AW+W handshake in cycle 0 puts we=1 in cycle 1.
  - If wdone=1 in cycle 1, we=1 for exactly one cycle and bvalid=1 in cycle 2.
  - AW in cycle 0 and W in cycle 3: we rises in cycle 4.
- Read path:
  - AR handshake in cycle 0 puts re=1 in cycle 1.
  - rdone in cycle 1 gives rvalid=1 in cycle 2, with s_axi_rdata equal to the cycle-1 rdata.
- Strobes drop the cycle after done is sampled. They never stay high past done.
- bvalid/rvalid stay asserted and their payloads stay stable until the ready handshake, regardless of how long ready is held low.
- Back-to-back: the IDLE after a B/R handshake accepts a new address in the next cycle. Sustained throughput is one transaction per 3 cycles per direction.
- rst asserted mid-transaction: the transaction is abandoned and all outputs return to reset values asynchronously. No response is issued after release.

## Test plan
- AW and W in the same cycle: awaddr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF, wdone tied to we -> we high 1 cycle with waddr=0x10 and wdata=0xDEADBEEF; bvalid cycle 2, bresp=00.
- W three cycles before AW, awaddr=0x8000_0004, wdone delayed 5 cycles, bready low 4 cycles -> we held 6 cycles; bvalid/bresp=00 held stable until bready.
- awaddr=0xC000_0000 -> bresp=11, we never asserted. wstrb=0x3 at addr 0x0 -> bresp=10, we never asserted.
- Read 0x0000_0008 with rdone=1 and rdata=0x1234_5678 on the 2nd re cycle -> rvalid with rdata=0x12345678, rresp=00. Concurrently a write completes independently.
- TIMEOUT=4 and wdone/rdone held low -> we and re each high exactly 4 cycles; bresp=10; rresp=10 with rdata=0.
- rst pulsed while in W_EXEC and R_RESP -> all outputs 0 immediately; after release only readies are high and no stale bvalid/rvalid appears.
